seq_stim_ctrl: RTL and testbench
================================

SEQ_STIM_CTRL -- requirements
Module: seq_stim_ctrl

Interface
REQ-001 Parameter PAT_W, default 8: maximum stimulus pattern length in bits.
REQ-002 Parameter SETTLE, default 2: cycles ser_out is held at 0 after the last pattern bit, before capture (legal range 1..15).
REQ-003 Derived constants: LEN_W = clog2(PAT_W+1); CNT_W = clog2(PAT_W+SETTLE+1).
REQ-004 clk  input  1  single clock; all logic is on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 pat_valid  input  1  stimulus request valid.
REQ-007 pat_data  input  PAT_W  stimulus bits, sent LSB first.
REQ-008 pat_len  input  LEN_W  number of bits to send.
REQ-009 pat_ready  output  1  controller can accept a request.
REQ-010 abort  input  1  cancel the run in progress.
REQ-011 dp_rst  output  1  reset pulse to the sequential datapath under test.
REQ-012 ser_out  output  1  serial stimulus driving the datapath input.
REQ-013 obs_a, obs_b, obs_c  input  1 each  datapath outputs.
REQ-014 res_valid  output  1  result available.
REQ-015 res_data  output  CNT_W+3  {hit_a_cnt, obs_a, obs_b, obs_c}.
REQ-016 res_ready  input  1  result consumer ready.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 The FSM has the states IDLE, CLR, SHIFT, SETTLE and RESP.
REQ-019 pat_ready = (state==IDLE) && !rst; a request is accepted on an edge where pat_valid && pat_ready, and pat_data and pat_len are latched at that edge.
REQ-020 Length handling: pat_len > PAT_W is clamped to PAT_W; pat_len = 0 goes CLR -> SETTLE with no SHIFT cycles.
REQ-021 Next-state rules: IDLE -> CLR on accept; CLR lasts exactly 1 cycle with dp_rst=1 and ser_out=0.
REQ-022 SHIFT lasts len cycles; in the i-th SHIFT cycle (i = 0..len-1), ser_out = latched pat_data[i] and dp_rst=0.
REQ-023 SETTLE lasts SETTLE cycles with ser_out=0.
REQ-024 On the final SETTLE edge, obs_a, obs_b and obs_c are captured into res_data[2:0] and the FSM enters RESP.
REQ-025 hit_a_cnt clears in CLR and increments on each SHIFT or SETTLE edge where obs_a=1; it saturates at 2^CNT_W-1, which is never reached for legal parameters.
REQ-026 In RESP, res_valid=1 and res_data is held stable until an edge with res_ready=1; the FSM then returns to IDLE.
REQ-027 res_valid rises exactly 2+len+SETTLE-1 edges after the accepting edge, i.e. latency = len+SETTLE+1 cycles from accept to the first RESP cycle.
REQ-028 abort=1 in CLR, SHIFT or SETTLE: the FSM enters IDLE on the next edge, no result is produced, and ser_out=0 from that edge on.
REQ-029 abort in IDLE is ignored.
REQ-030 abort and res_ready both high in RESP: the transfer is counted as completed and the FSM returns to IDLE.
REQ-031 A new request is never accepted in the cycle RESP completes; pat_ready rises the cycle after return to IDLE.
REQ-032 ser_out and dp_rst are registered outputs, free of glitches and of combinational paths from inputs.

Reset
REQ-033 While rst=1 at an edge: state=IDLE, dp_rst=1, ser_out=0, res_valid=0, res_data=0, hit_a_cnt=0, busy=0, pat_ready=0.
REQ-034 Reset asserted mid-run discards the run; no partial result is delivered.
REQ-035 After rst deasserts, dp_rst=0 and pat_ready=1 from the first post-reset edge.

Structure
REQ-036 Package seq_stim_pkg holds the FSM state enum, the PAT_W and SETTLE defaults, and the LEN_W/CNT_W derivation functions.
REQ-037 The pattern shifter (load, shift right, bit0 -> ser_out) is a sub-module, seq_stim_shreg.
REQ-038 The FSM, counters and result register stay in seq_stim_ctrl.

Verification
REQ-039 Basic run (PAT_W=8, SETTLE=2): pat_data=8'h05, pat_len=3, res_ready=1 -> dp_rst pulse for 1 cycle, then ser_out 1,0,1,0,0, then res_valid 6 cycles after accept.
REQ-040 Count check: same run with obs_a tied to 1 -> res_data = {hit_a_cnt=5, 1, obs_b, obs_c}.
REQ-041 Zero length: pat_len=0 -> no SHIFT cycles; res_valid 3 cycles after accept; hit_a_cnt <= 2.
REQ-042 Clamp and backpressure: pat_len=12, res_ready=0 for 4 cycles -> 8 bits shifted; res_valid and res_data held 4 cycles; IDLE after the handshake.
REQ-043 Abort: abort pulsed in the 2nd SHIFT cycle -> IDLE next edge, res_valid never rises, and the next request runs normally.
REQ-044 Reset mid-run: rst in SETTLE -> all outputs at reset values next edge; pat_ready=1 one edge after rst drops.

Source files
------------

// File: rtl/seq_stim_pkg.sv
// Shared definitions for the stimulus sequencer: FSM states, default
// sizing and the width helpers used to size length and cycle counters.
package seq_stim_pkg;

    localparam int PAT_W_DEF  = 8;
    localparam int SETTLE_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLR    = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    // Bits needed to hold a length of 0..pat_w.
    function automatic int len_width(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

    // Bits needed to count every SHIFT and SETTLE cycle of one run.
    function automatic int cnt_width(input int pat_w, input int settle);
        return $clog2(pat_w + settle + 1);
    endfunction

endpackage

// File: rtl/seq_stim_shreg.sv
// Pattern shifter: loads a stimulus word, then presents it LSB first on a
// registered serial output. The output is forced to 0 whenever the shifter
// is not advancing, so the datapath sees a clean low outside SHIFT.
module seq_stim_shreg
    import seq_stim_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             load,
    input  logic             shift,
    input  logic [PAT_W-1:0] load_data,
    output logic             ser_out
);

    logic [PAT_W-1:0] data_reg;
    logic [PAT_W-1:0] data_shifted;
    logic             ser_reg;

    // Right-shift network: each bit takes its upper neighbour, MSB fills with 0.
    generate
        for (genvar gi = 0; gi < PAT_W; gi++) begin : g_shift
            if (gi == PAT_W - 1) begin : g_msb
                assign data_shifted[gi] = 1'b0;
            end else begin : g_lower
                assign data_shifted[gi] = data_reg[gi + 1];
            end
        end
    endgenerate

    // Pattern register and serial output register.
    always_ff @(posedge clk) begin
        if (srst) begin
            data_reg <= '0;
            ser_reg  <= 1'b0;
        end else if (load) begin
            data_reg <= load_data;
            ser_reg  <= 1'b0;
        end else if (shift) begin
            data_reg <= data_shifted;
            ser_reg  <= data_reg[0];
        end else begin
            ser_reg  <= 1'b0;
        end
    end

    assign ser_out = ser_reg;

endmodule

// File: rtl/seq_stim_ctrl.sv
// Stimulus sequencer for a sequential datapath under test: pulses the
// datapath reset, shifts a pattern in serially, waits a settle window,
// then captures the datapath outputs plus a count of obs_a hits and
// offers them on a valid/ready result port.
module seq_stim_ctrl
    import seq_stim_pkg::*;
#(
    parameter  int PAT_W  = PAT_W_DEF,
    parameter  int SETTLE = SETTLE_DEF,
    localparam int LEN_W  = len_width(PAT_W),
    localparam int CNT_W  = cnt_width(PAT_W, SETTLE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pat_valid,
    input  logic [PAT_W-1:0] pat_data,
    input  logic [LEN_W-1:0] pat_len,
    output logic             pat_ready,
    input  logic             abort,
    output logic             dp_rst,
    output logic             ser_out,
    input  logic             obs_a,
    input  logic             obs_b,
    input  logic             obs_c,
    output logic             res_valid,
    output logic [CNT_W+2:0] res_data,
    input  logic             res_ready,
    output logic             busy
);

    localparam logic [LEN_W-1:0] LEN_MAX    = LEN_W'(PAT_W);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] HIT_SAT    = {CNT_W{1'b1}};

    state_t           state_reg, state_next;
    logic [LEN_W-1:0] len_reg, len_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] hit_reg, hit_next;
    logic [CNT_W+2:0] res_reg, res_next;
    logic             dp_rst_reg, dp_rst_next;

    logic             accept;
    logic             load_en;
    logic             shift_en;
    logic [LEN_W-1:0] len_clamped;
    logic [CNT_W-1:0] hit_inc;
    logic [CNT_W-1:0] shift_last;

    assign pat_ready   = (state_reg == ST_IDLE) && !rst;
    assign accept      = pat_valid && pat_ready;
    assign len_clamped = (pat_len > LEN_MAX) ? LEN_MAX : pat_len;
    assign hit_inc     = (obs_a && (hit_reg != HIT_SAT)) ? hit_reg + CNT_ONE : hit_reg;
    assign shift_last  = CNT_W'(len_reg) - CNT_ONE;

    // Next-state, counter and capture logic; abort takes priority in the run states.
    always_comb begin
        state_next = state_reg;
        len_next   = len_reg;
        cnt_next   = cnt_reg;
        hit_next   = hit_reg;
        res_next   = res_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_CLR;
                    len_next   = len_clamped;
                end
            end
            ST_CLR: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else begin
                    hit_next   = '0;
                    cnt_next   = '0;
                    state_next = (len_reg == '0) ? ST_SETTLE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else begin
                    hit_next = hit_inc;
                    if (cnt_reg == shift_last) begin
                        state_next = ST_SETTLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next   = cnt_reg + CNT_ONE;
                    end
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else begin
                    hit_next = hit_inc;
                    if (cnt_reg == SETTLE_END) begin
                        state_next = ST_RESP;
                        res_next   = {hit_inc, obs_a, obs_b, obs_c};
                    end else begin
                        cnt_next   = cnt_reg + CNT_ONE;
                    end
                end
            end
            ST_RESP: begin
                if (res_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Outputs are registered from the upcoming state so they never glitch.
        dp_rst_next = (state_next == ST_CLR);
        shift_en    = (state_next == ST_SHIFT);
        load_en     = accept;
    end

    // State, counters, result register and datapath reset output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            len_reg    <= '0;
            cnt_reg    <= '0;
            hit_reg    <= '0;
            res_reg    <= '0;
            dp_rst_reg <= 1'b1;
        end else begin
            state_reg  <= state_next;
            len_reg    <= len_next;
            cnt_reg    <= cnt_next;
            hit_reg    <= hit_next;
            res_reg    <= res_next;
            dp_rst_reg <= dp_rst_next;
        end
    end

    seq_stim_shreg #(
        .PAT_W(PAT_W)
    ) u_shreg (
        .clk      (clk),
        .srst     (rst),
        .load     (load_en),
        .shift    (shift_en),
        .load_data(pat_data),
        .ser_out  (ser_out)
    );

    assign dp_rst    = dp_rst_reg;
    assign res_valid = (state_reg == ST_RESP);
    assign res_data  = res_reg;
    assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_seq_stim_ctrl.sv
// Self-checking bench for seq_stim_ctrl: directed runs followed by random
// runs, each predicted from the cycle-by-cycle behaviour of a run.
module tb_seq_stim_ctrl;

    localparam int PAT_W  = 8;
    localparam int SETTLE = 2;
    localparam int LEN_W  = 4;
    localparam int CNT_W  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             pat_valid;
    logic [PAT_W-1:0] pat_data;
    logic [LEN_W-1:0] pat_len;
    logic             pat_ready;
    logic             abort;
    logic             dp_rst;
    logic             ser_out;
    logic             obs_a, obs_b, obs_c;
    logic             res_valid;
    logic [CNT_W+2:0] res_data;
    logic             res_ready;
    logic             busy;

    int total = 0;
    int bad   = 0;

    seq_stim_ctrl #(
        .PAT_W (PAT_W),
        .SETTLE(SETTLE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pat_valid(pat_valid),
        .pat_data (pat_data),
        .pat_len  (pat_len),
        .pat_ready(pat_ready),
        .abort    (abort),
        .dp_rst   (dp_rst),
        .ser_out  (ser_out),
        .obs_a    (obs_a),
        .obs_b    (obs_b),
        .obs_c    (obs_c),
        .res_valid(res_valid),
        .res_data (res_data),
        .res_ready(res_ready),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One request. kill_kind: 0 none, 1 abort, 2 reset, applied during cycle kill_cyc
    // (cycle 0 = CLR). bp = RESP cycles with res_ready low before the handshake.
    task automatic do_run(input logic [7:0] d, input int l, input int mode, input int bp,
                          input int kill_kind, input int kill_cyc,
                          input bit abort_resp, input bit abort_idle);
        int         eff;
        int         hits;
        logic [2:0] cap;
        logic       exp_ser;
        logic [6:0] exp_res;
        eff  = (l > PAT_W) ? PAT_W : l;
        hits = 0;
        cap  = 3'b000;
        $display("run: data=%02h len=%0d eff=%0d bp=%0d kill=%0d@%0d", d, l, eff, bp, kill_kind, kill_cyc);
        check("idle_ready", 32'(pat_ready), 32'(1));
        pat_valid = 1'b1;
        pat_data  = d;
        pat_len   = LEN_W'(l);
        res_ready = (bp == 0);
        abort     = abort_idle;
        step();
        pat_valid = 1'b0;
        abort     = 1'b0;
        pat_data  = PAT_W'($urandom);
        pat_len   = LEN_W'($urandom);
        for (int c = 0; c <= eff + SETTLE; c++) begin
            exp_ser = 1'b0;
            if (c >= 1 && c <= eff) exp_ser = d[c-1];
            check("run_busy", 32'(busy), 32'(1));
            check("run_res_valid", 32'(res_valid), 32'(0));
            check("run_pat_ready", 32'(pat_ready), 32'(0));
            check("run_dp_rst", 32'(dp_rst), 32'(c == 0));
            check("run_ser_out", 32'(ser_out), 32'(exp_ser));
            obs_a = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            obs_b = 1'($urandom_range(0, 1));
            obs_c = 1'($urandom_range(0, 1));
            if (c >= 1 && obs_a) hits++;
            if (c == eff + SETTLE) cap = {obs_a, obs_b, obs_c};
            if (kill_kind == 1 && c == kill_cyc) begin
                abort = 1'b1;
                step();
                abort = 1'b0;
                check("abort_busy", 32'(busy), 32'(0));
                check("abort_ser", 32'(ser_out), 32'(0));
                check("abort_dp_rst", 32'(dp_rst), 32'(0));
                check("abort_pat_ready", 32'(pat_ready), 32'(1));
                for (int k = 0; k < 3; k++) begin
                    check("abort_res_valid", 32'(res_valid), 32'(0));
                    check("abort_ser_idle", 32'(ser_out), 32'(0));
                    step();
                end
                return;
            end
            if (kill_kind == 2 && c == kill_cyc) begin
                rst = 1'b1;
                step();
                check("mrst_dp_rst", 32'(dp_rst), 32'(1));
                check("mrst_ser", 32'(ser_out), 32'(0));
                check("mrst_res_valid", 32'(res_valid), 32'(0));
                check("mrst_res_data", 32'(res_data), 32'(0));
                check("mrst_busy", 32'(busy), 32'(0));
                check("mrst_pat_ready", 32'(pat_ready), 32'(0));
                rst = 1'b0;
                step();
                check("mrst_after_ready", 32'(pat_ready), 32'(1));
                check("mrst_after_dp_rst", 32'(dp_rst), 32'(0));
                check("mrst_after_valid", 32'(res_valid), 32'(0));
                return;
            end
            step();
        end
        exp_res = {CNT_W'(hits), cap};
        for (int i = 0; i < bp; i++) begin
            check("bp_res_valid", 32'(res_valid), 32'(1));
            check("bp_res_data", 32'(res_data), 32'(exp_res));
            check("bp_pat_ready", 32'(pat_ready), 32'(0));
            pat_valid = 1'b1;
            step();
        end
        res_ready = 1'b1;
        pat_valid = 1'b1;
        abort     = abort_resp;
        check("resp_valid", 32'(res_valid), 32'(1));
        check("resp_data", 32'(res_data), 32'(exp_res));
        check("resp_ser", 32'(ser_out), 32'(0));
        check("resp_pat_ready", 32'(pat_ready), 32'(0));
        step();
        res_ready = 1'b0;
        pat_valid = 1'b0;
        abort     = 1'b0;
        check("done_busy", 32'(busy), 32'(0));
        check("done_valid", 32'(res_valid), 32'(0));
        check("done_dp_rst", 32'(dp_rst), 32'(0));
        check("done_pat_ready", 32'(pat_ready), 32'(1));
        $display("result: data=%02h hits=%0d cap=%03b", d, hits, cap);
    endtask

    initial begin
        int l;
        int eff;
        rst       = 1'b1;
        pat_valid = 1'b0;
        pat_data  = '0;
        pat_len   = '0;
        abort     = 1'b0;
        obs_a     = 1'b0;
        obs_b     = 1'b0;
        obs_c     = 1'b0;
        res_ready = 1'b0;
        step();
        step();
        check("rst_dp_rst", 32'(dp_rst), 32'(1));
        check("rst_ser", 32'(ser_out), 32'(0));
        check("rst_res_valid", 32'(res_valid), 32'(0));
        check("rst_res_data", 32'(res_data), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_pat_ready", 32'(pat_ready), 32'(0));
        rst = 1'b0;
        step();
        check("post_rst_dp_rst", 32'(dp_rst), 32'(0));
        check("post_rst_ready", 32'(pat_ready), 32'(1));

        // Basic run, then the same run with obs_a held high (5 hits).
        do_run(8'h05, 3, 0, 0, 0, 0, 1'b0, 1'b0);
        do_run(8'h05, 3, 1, 0, 0, 0, 1'b0, 1'b0);
        check("hit5_count", 32'(res_data[6:3]), 32'(5));
        // Zero length, then length clamp with backpressure.
        do_run(8'hA7, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        do_run(8'hC9, 12, 1, 4, 0, 0, 1'b0, 1'b0);
        check("clamp_count", 32'(res_data[6:3]), 32'(10));
        // Abort in the 2nd SHIFT cycle, then a normal run.
        do_run(8'h3C, 5, 0, 0, 1, 2, 1'b0, 1'b0);
        do_run(8'h96, 4, 0, 1, 0, 0, 1'b0, 1'b0);
        // Reset in the first SETTLE cycle, then a normal run.
        do_run(8'h05, 3, 0, 0, 2, 4, 1'b0, 1'b0);
        do_run(8'h5A, 8, 0, 0, 0, 0, 1'b1, 1'b1);

        // Random runs, including abort-with-handshake and abort while idle.
        for (int r = 0; r < 25; r++) begin
            l   = $urandom_range(0, 15);
            eff = (l > PAT_W) ? PAT_W : l;
            if ($urandom_range(0, 3) == 0)
                do_run(8'($urandom), l, 0, 0, 1, $urandom_range(0, eff + SETTLE), 1'b0, 1'b0);
            else
                do_run(8'($urandom), l, 0, $urandom_range(0, 3), 0, 0,
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
